// File: rtl/vga_block_capture_if.sv
// Video input and image-BRAM write port bundle for vga_block_capture.
// The capture block takes the slave view; whatever drives the video takes the master view.
interface vga_block_capture_if;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [7:0]  rgb;
    logic [15:0] bram_addr;
    logic [7:0]  bram_din;
    logic        bram_we;

    modport master (
        output pix_en, hsync, vsync, rgb,
        input  bram_addr, bram_din, bram_we
    );

    modport slave (
        input  pix_en, hsync, vsync, rgb,
        output bram_addr, bram_din, bram_we
    );
endinterface

// File: rtl/vga_block_capture.sv
// Loopback capture of a VGA frame: one centre-pixel byte per cell of the centred window,
// written to an image slot in BRAM. Define CAPTURE_CHECKSUM_EN to add the checksum output.
module vga_block_capture #(
    parameter int unsigned PIXEL_WIDTH  = 640,
    parameter int unsigned PIXEL_HEIGHT = 480,
    parameter int unsigned HBP          = 48,
    parameter int unsigned VBP          = 33,
    parameter int unsigned BLOCK_SIZE   = 16,
    parameter int unsigned BLOCKS_WIDE  = 28,
    parameter int unsigned BLOCKS_HIGH  = 28,
    parameter int unsigned SLOT_STRIDE  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    vga_block_capture_if.slave  vid,
    input  logic                arm,
    input  logic [3:0]          slot,
    output logic                busy,
    output logic                done,
    output logic                frame_err
`ifdef CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]         checksum
`endif
);

    localparam int unsigned X0 = (PIXEL_WIDTH - BLOCK_SIZE * BLOCKS_WIDE) / 2;
    localparam int unsigned Y0 = (PIXEL_HEIGHT - BLOCK_SIZE * BLOCKS_HIGH) / 2;

    localparam logic [15:0] XS      = 16'(HBP + X0);
    localparam logic [15:0] YS      = 16'(VBP + Y0);
    localparam logic [15:0] HALF    = 16'(BLOCK_SIZE / 2);
    localparam logic [15:0] BS_LAST = 16'(BLOCK_SIZE - 1);
    localparam logic [15:0] BW      = 16'(BLOCKS_WIDE);
    localparam logic [15:0] BH      = 16'(BLOCKS_HIGH);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StWaitVs,
        StCapture,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [3:0]  slot_q, slot_d;

    logic        hs_prev_q, vs_prev_q;
    logic        hs_rise, vs_rise, vs_fall;

    logic [15:0] x_q, x_now;
    logic [15:0] col_q, col_now;
    logic [15:0] subx_q, subx_now;
    logic        col_hit;

    logic [15:0] y_q, y_nxt;
    logic [15:0] row_q, row_nxt;
    logic [15:0] suby_q, suby_nxt;
    logic        row_hit;

    logic        sample;
    logic        we_q, we_d;
    logic        last_q, last_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;

    // ------------------------------------------------------------------
    // Sync edge detection, evaluated only on pixel strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else if (vid.pix_en) begin
            hs_prev_q <= vid.hsync;
            vs_prev_q <= vid.vsync;
        end
    end

    assign hs_rise = vid.pix_en & vid.hsync & ~hs_prev_q;
    assign vs_rise = vid.pix_en & vid.vsync & ~vs_prev_q;
    assign vs_fall = vid.pix_en & ~vid.vsync & vs_prev_q;

    // ------------------------------------------------------------------
    // Horizontal position: x of the current strobe plus cell column/phase
    // ------------------------------------------------------------------
    always_comb begin
        x_now    = (x_q == CNT_MAX) ? x_q : x_q + 16'd1;
        col_now  = col_q;
        subx_now = subx_q;
        if (hs_rise) begin
            x_now = '0;
        end
        if (x_now <= XS) begin
            col_now  = '0;
            subx_now = '0;
        end else if (subx_q == BS_LAST) begin
            subx_now = '0;
            col_now  = (col_q == BW) ? col_q : col_q + 16'd1;
        end else begin
            subx_now = subx_q + 16'd1;
        end
        col_hit = (x_now >= XS) && (col_now < BW) && (subx_now == HALF);
    end

    // ------------------------------------------------------------------
    // Vertical position: advanced once per line; the hsync edge that
    // coincides with the vsync edge is line 0, not an increment
    // ------------------------------------------------------------------
    always_comb begin
        y_nxt    = y_q;
        row_nxt  = row_q;
        suby_nxt = suby_q;
        if (vs_rise) begin
            y_nxt    = '0;
            row_nxt  = '0;
            suby_nxt = '0;
        end else if (hs_rise) begin
            y_nxt = (y_q == CNT_MAX) ? y_q : y_q + 16'd1;
            if (y_nxt <= YS) begin
                row_nxt  = '0;
                suby_nxt = '0;
            end else if (suby_q == BS_LAST) begin
                suby_nxt = '0;
                row_nxt  = (row_q == BH) ? row_q : row_q + 16'd1;
            end else begin
                suby_nxt = suby_q + 16'd1;
            end
        end
    end

    assign row_hit = (y_q >= YS) && (row_q < BH) && (suby_q == HALF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            col_q  <= '0;
            subx_q <= '0;
            y_q    <= '0;
            row_q  <= '0;
            suby_q <= '0;
        end else if (vid.pix_en) begin
            x_q    <= x_now;
            col_q  <= col_now;
            subx_q <= subx_now;
            y_q    <= y_nxt;
            row_q  <= row_nxt;
            suby_q <= suby_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Cell sampling and the registered BRAM write one cycle later
    // ------------------------------------------------------------------
    assign sample = (state_q == StCapture) && vid.pix_en && col_hit && row_hit;

    always_comb begin
        we_d   = sample;
        last_d = sample && (col_now == BW - 16'd1) && (row_q == BH - 16'd1);
        addr_d = addr_q;
        din_d  = din_q;
        if (sample) begin
            addr_d = 16'(32'(slot_q) * SLOT_STRIDE + 32'(row_q) * BLOCKS_WIDE + 32'(col_now));
            din_d  = vid.rgb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            last_q <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            we_q   <= we_d;
            last_q <= last_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign vid.bram_we   = we_q;
    assign vid.bram_addr = addr_q;
    assign vid.bram_din  = din_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StWaitVs;
                    slot_d  = (slot > 4'd9) ? 4'd0 : slot;
                end
            end
            StWaitVs: begin
                // Counters restart on this same strobe, so capture begins at frame top
                if (vs_rise) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (we_q && last_q) begin
                    state_d = StDone;
                end else if (vs_fall) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    assign busy      = (state_q == StWaitVs) || (state_q == StCapture);
    assign done      = (state_q == StDone);
    assign frame_err = (state_q == StErr);

`ifdef CAPTURE_CHECKSUM_EN
    // Accumulated at the sampling edge so the last byte is included by the done pulse
    logic [15:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == StIdle && arm) begin
            chk_d = '0;
        end else if (sample) begin
            chk_d = chk_q + {8'd0, vid.rgb};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`endif

endmodule
